fetch_queue: RTL and testbench

Parametrised, multi-entry instruction buffer between the IF stage and ID.
- Successor to the single-register fetch/decode pipeline stage: same payload (instruction, PC, PC+4), same FLUSH/STALL semantics.
- Adds DEPTH-entry FIFO buffering, a valid/ready handshake on the IF side and a valid flag on the ID side. IF can keep fetching while ID stalls.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue_if.sv | 36 +++
 rtl/fetch_queue_ptr.sv | 51 +++++
 rtl/fetch_queue.sv | 83 ++++++++
 tb/tb_fetch_queue.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch queue: default data width and the
// fetch_entry_t payload {instr, pc, pc_plus4} stored per entry.
package fetch_pkg;

   localparam int DATA_W_DEF = 32;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] instr;
      logic [DATA_W_DEF-1:0] pc;
      logic [DATA_W_DEF-1:0] pc_plus4;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// IF/ID bus of the fetch queue. master = IF+ID side (producer/consumer),
// slave = queue. IF: IF_VALID/IF_READY + payload; ID: STALL, OUT_VALID,
// head payload, COUNT.
interface fetch_queue_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
);
   localparam int PTR_W = $clog2(DEPTH);

   logic              IF_VALID;
   logic              IF_READY;
   logic [DATA_W-1:0] Instr1_IF;
   logic [DATA_W-1:0] Instr_PC_IF;
   logic [DATA_W-1:0] Instr_PC_Plus4_IF;
   logic              STALL;
   logic              OUT_VALID;
   logic [DATA_W-1:0] Instr1_OUT;
   logic [DATA_W-1:0] Instr_PC_OUT;
   logic [DATA_W-1:0] Instr_PC_Plus4;
   logic [PTR_W:0]    COUNT;

   modport master (
      output IF_VALID, Instr1_IF, Instr_PC_IF,
             Instr_PC_Plus4_IF, STALL,
      input  IF_READY, OUT_VALID, Instr1_OUT,
             Instr_PC_OUT, Instr_PC_Plus4, COUNT
   );

   modport slave (
      input  IF_VALID, Instr1_IF, Instr_PC_IF,
             Instr_PC_Plus4_IF, STALL,
      output IF_READY, OUT_VALID, Instr1_OUT,
             Instr_PC_OUT, Instr_PC_Plus4, COUNT
   );

endinterface

// File: rtl/fetch_queue_ptr.sv
// Read/write pointers and occupancy of the fetch queue.
// Ports: CLK, RESET (async low), FLUSH, if_valid, stall in;
// push, pop, rd_ptr, wr_ptr, count, full, empty out.
module fetch_queue_ptr #(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             FLUSH,
   input  logic             if_valid,
   input  logic             stall,
   output logic             push,
   output logic             pop,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty
);

   localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

   assign full  = (count == CNT_MAX);
   assign empty = (count == '0);
   // full blocks a push even when a pop frees a slot this cycle,
   // keeping STALL out of the IF_READY path
   assign push  = if_valid && !full;
   assign pop   = !empty && !stall;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (FLUSH) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// DEPTH-entry IF->ID instruction buffer. Ports: CLK, RESET (async low),
// FLUSH, bus (fetch_queue_if.slave); with FETCH_QUEUE_PERF_EN also
// PERF_FULL_CYC / PERF_STALL_CYC saturating cycle counters.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int DEPTH  = 4,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        FLUSH,
`ifdef FETCH_QUEUE_PERF_EN
   output logic [31:0] PERF_FULL_CYC,
   output logic [31:0] PERF_STALL_CYC,
`endif
   fetch_queue_if.slave bus
);

   logic             push;
   logic             pop;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             full;
   logic             empty;

   fetch_entry_t mem [DEPTH];
   fetch_entry_t wr_entry;
   fetch_entry_t head;

   fetch_queue_ptr #(.DEPTH(DEPTH)) u_ptr (
      .CLK      (CLK),
      .RESET    (RESET),
      .FLUSH    (FLUSH),
      .if_valid (bus.IF_VALID),
      .stall    (bus.STALL),
      .push     (push),
      .pop      (pop),
      .rd_ptr   (rd_ptr),
      .wr_ptr   (wr_ptr),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   assign wr_entry.instr    = bus.Instr1_IF;
   assign wr_entry.pc       = bus.Instr_PC_IF;
   assign wr_entry.pc_plus4 = bus.Instr_PC_Plus4_IF;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !FLUSH) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   // stale storage after a flush is hidden by the empty mask
   assign head           = mem[rd_ptr];
   assign bus.IF_READY   = !full;
   assign bus.OUT_VALID  = !empty;
   assign bus.COUNT      = count;
   assign bus.Instr1_OUT     = empty ? '0 : head.instr;
   assign bus.Instr_PC_OUT   = empty ? '0 : head.pc;
   assign bus.Instr_PC_Plus4 = empty ? '0 : head.pc_plus4;

`ifdef FETCH_QUEUE_PERF_EN
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         PERF_FULL_CYC  <= '0;
         PERF_STALL_CYC <= '0;
      end else begin
         if (bus.IF_VALID && full && (PERF_FULL_CYC != '1))
            PERF_FULL_CYC <= PERF_FULL_CYC + 32'd1;
         if (!empty && bus.STALL && (PERF_STALL_CYC != '1))
            PERF_STALL_CYC <= PERF_STALL_CYC + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, DATA_W=32).
// Covers reset, latency, fill/full, drain, push+pop, flush, async reset.
module tb_fetch_queue;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   int   n_cmp = 0;
   int   n_err = 0;

   fetch_queue_if #(.DATA_W(32), .DEPTH(4)) bus ();

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] perf_full;
   logic [31:0] perf_stall;
`endif

   fetch_queue #(.DATA_W(32), .DEPTH(4)) dut (
      .CLK            (clk),
      .RESET          (rst_n),
      .FLUSH          (flush),
`ifdef FETCH_QUEUE_PERF_EN
      .PERF_FULL_CYC  (perf_full),
      .PERF_STALL_CYC (perf_stall),
`endif
      .bus            (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ins(input logic [31:0] pc);
      return pc ^ 32'hDEAD_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc);
      bus.IF_VALID          = v;
      bus.Instr_PC_IF       = pc;
      bus.Instr1_IF         = ins(pc);
      bus.Instr_PC_Plus4_IF = pc + 32'd4;
   endtask

   task automatic chk_head(input string tag, input logic [31:0] pc);
      chk({tag, ".vld"}, 32'(bus.OUT_VALID), 32'd1);
      chk({tag, ".pc"}, bus.Instr_PC_OUT, pc);
      chk({tag, ".ins"}, bus.Instr1_OUT, ins(pc));
      chk({tag, ".pc4"}, bus.Instr_PC_Plus4, pc + 32'd4);
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, ".vld"}, 32'(bus.OUT_VALID), 32'd0);
      chk({tag, ".rdy"}, 32'(bus.IF_READY), 32'd1);
      chk({tag, ".cnt"}, 32'(bus.COUNT), 32'd0);
      chk({tag, ".pc"}, bus.Instr_PC_OUT, 32'd0);
      chk({tag, ".ins"}, bus.Instr1_OUT, 32'd0);
      chk({tag, ".pc4"}, bus.Instr_PC_Plus4, 32'd0);
   endtask

   task automatic chk_cnt(input string tag, input logic [31:0] c);
      chk({tag, ".cnt"}, 32'(bus.COUNT), c);
   endtask

   task automatic chk_perf(input string tag, input logic [31:0] f,
                           input logic [31:0] s);
`ifdef FETCH_QUEUE_PERF_EN
      chk({tag, ".pfull"}, perf_full, f);
      chk({tag, ".pstall"}, perf_stall, s);
`else
      if (f != s) begin end
      if (tag == "") begin end
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      bus.STALL = 1'b0;
      drive(1'b1, 32'h0040_0000);
      step();
      step();
      chk_empty("reset");
      chk_perf("reset", 32'd0, 32'd0);

      rst_n = 1'b1;
      #1;
      chk("nobypass.vld", 32'(bus.OUT_VALID), 32'd0);
      step();
      chk_head("lat", 32'h0040_0000);
      chk_cnt("lat", 32'd1);
      bus.IF_VALID = 1'b0;
      step();
      chk_empty("pop1");

      bus.STALL = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h0040_0000 + 32'(4 * i));
         step();
      end
      chk_cnt("full", 32'd4);
      chk("full.rdy", 32'(bus.IF_READY), 32'd0);
      chk_head("full", 32'h0040_0000);
      drive(1'b1, 32'h0040_0010);
      repeat (5) step();
      chk_cnt("hold", 32'd4);
      chk_head("hold", 32'h0040_0000);
      chk_perf("hold", 32'd5, 32'd8);

      bus.STALL = 1'b0;
      #1;
      chk("nostallpath.rdy", 32'(bus.IF_READY), 32'd0);
      step();
      chk_head("drain1", 32'h0040_0004);
      chk_cnt("drain1", 32'd3);
      bus.IF_VALID = 1'b0;
      step();
      chk_head("drain2", 32'h0040_0008);
      chk_cnt("drain2", 32'd2);
      step();
      chk_head("drain3", 32'h0040_000C);
      chk_cnt("drain3", 32'd1);
      step();
      chk_empty("drained");
      chk_perf("drained", 32'd6, 32'd8);

      bus.STALL = 1'b1;
      drive(1'b1, 32'h0040_0020);
      step();
      drive(1'b1, 32'h0040_0024);
      step();
      chk_cnt("pp.pre", 32'd2);
      chk_head("pp.pre", 32'h0040_0020);
      bus.STALL = 1'b0;
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 32'h0040_0028 + 32'(4 * k));
         step();
         chk_cnt("pp", 32'd2);
         chk("pp.pc", bus.Instr_PC_OUT,
             32'h0040_0024 + 32'(4 * k));
      end
      bus.IF_VALID = 1'b0;
      step();
      chk_head("pp.tail", 32'h0040_004C);
      chk_cnt("pp.tail", 32'd1);
      step();
      chk_empty("pp.end");
      chk_perf("pp.end", 32'd6, 32'd9);

      bus.STALL = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h0040_0200 + 32'(4 * i));
         step();
      end
      chk_cnt("preflush", 32'd3);
      flush = 1'b1;
      drive(1'b1, 32'h0040_0100);
      step();
      chk_empty("flush");
      chk_perf("flush", 32'd6, 32'd12);
      flush = 1'b0;
      bus.IF_VALID = 1'b0;
      bus.STALL = 1'b0;
      step();
      chk_empty("postflush");
      chk_perf("postflush", 32'd6, 32'd12);
      drive(1'b1, 32'h0040_0300);
      step();
      bus.IF_VALID = 1'b0;
      bus.STALL = 1'b1;
      chk_head("reuse", 32'h0040_0300);
      chk_cnt("reuse", 32'd1);

      #2;
      rst_n = 1'b0;
      #1;
      chk_empty("areset");
      chk_perf("areset", 32'd0, 32'd0);
      rst_n = 1'b1;
      bus.STALL = 1'b0;
      step();
      chk_empty("areset.rel");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
